// File: rtl/usb_rx_rcu.sv
// ----------------------------------------------------------------------------
// usb_rx_rcu -- USB receiver control unit
//
// Tracks a packet from the first line transition through SYNC, PID, and the
// data phase to end of packet. It pushes each completed data byte into the
// RX FIFO and flags malformed packets.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   d_edge        one-cycle pulse on the first transition after idle J
//   shift_enable  one-cycle pulse at the centre of each bit time
//   eop_detected  high while the line is SE0
//   rcv_data      external RX shift register contents (LSB first on the wire)
//   rcving        high while a packet is in progress (including error drain)
//   w_enable      one-cycle FIFO push of rcv_data
//   r_error       sticky packet error, cleared by the next d_edge
//   pid           latched packet identifier
//   pid_valid     a good PID was seen in the current/last packet
//   pkt_done      one-cycle pulse on a clean end of packet
//   byte_count    data bytes written in the current/last packet
//
// State     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus idle, waiting for d_edge
// SYNC      | collecting the sync byte (must be 8'h80)
// PID       | collecting the PID byte (upper nibble = ~lower nibble)
// DATA      | collecting data bytes, pushing each one to the FIFO
// EOP       | SE0 seen on a byte boundary, waiting for J
// ERR       | packet is bad, ignoring bits until SE0
// ERR_EOP   | SE0 of a bad packet, waiting for J
// ----------------------------------------------------------------------------
module usb_rx_rcu #(
    parameter int MAX_BYTES = 66
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       shift_enable,
    input  logic       eop_detected,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [3:0] pid,
    output logic       pid_valid,
    output logic       pkt_done,
    output logic [6:0] byte_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_PID     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_EOP     = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;
    localparam logic [2:0] S_ERR_EOP = 3'd6;

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       counting;
    logic       se_eop;
    logic       se_j;
    logic       byte_room;
    logic       sync_ok;
    logic       pid_ok;

    assign counting  = (state == S_SYNC) || (state == S_PID) || (state == S_DATA);
    assign se_eop    = shift_enable & eop_detected;
    assign se_j      = shift_enable & ~eop_detected;
    assign byte_room = (byte_count < MAX_CNT);
    assign sync_ok   = (rcv_data == 8'h80);
    assign pid_ok    = (rcv_data[7:4] == ~rcv_data[3:0]);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (d_edge)
                    next_state = S_SYNC;
            end
            S_SYNC: begin
                if (byte_done)
                    next_state = sync_ok ? S_PID : S_ERR;
                if (se_eop)
                    next_state = S_ERR;
            end
            S_PID: begin
                if (byte_done)
                    next_state = pid_ok ? S_DATA : S_ERR;
                if (se_eop)
                    next_state = S_ERR;
            end
            S_DATA: begin
                // A byte completing in the same cycle as SE0 is written first
                // (w_enable is combinational on byte_done), then EOP is taken.
                if (se_eop)
                    next_state = (bit_cnt == 3'd0) ? S_EOP : S_ERR;
                if (byte_done && !byte_room)
                    next_state = S_ERR;
            end
            S_EOP: begin
                if (se_j)
                    next_state = S_IDLE;
            end
            S_ERR: begin
                if (se_eop)
                    next_state = S_ERR_EOP;
            end
            S_ERR_EOP: begin
                if (se_j)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Bit position within the current byte; byte_done lands one cycle after
    // the eighth bit so rcv_data already holds the complete byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= counting && shift_enable && (bit_cnt == 3'd7);
            if ((state == S_IDLE) && d_edge)
                bit_cnt <= 3'd0;
            else if (counting && shift_enable)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign rcving   = (state != S_IDLE);
    assign w_enable = (state == S_DATA) && byte_done && byte_room;
    assign pkt_done = (state == S_EOP) && se_j;

    // Packet status is held after the packet ends so software can read it,
    // and only cleared when the next packet starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid        <= 4'h0;
            pid_valid  <= 1'b0;
            byte_count <= 7'd0;
            r_error    <= 1'b0;
        end else begin
            if ((state == S_IDLE) && d_edge) begin
                pid_valid  <= 1'b0;
                byte_count <= 7'd0;
                r_error    <= 1'b0;
            end
            if ((state == S_PID) && (next_state == S_DATA)) begin
                pid       <= rcv_data[3:0];
                pid_valid <= 1'b1;
            end
            if (w_enable)
                byte_count <= byte_count + 7'd1;
            if (next_state == S_ERR)
                r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_rx_rcu.sv
module tb_usb_rx_rcu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       shift_enable = 1'b0;
    logic       eop_detected = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [3:0] pid;
    logic       pid_valid;
    logic       pkt_done;
    logic [6:0] byte_count;

    int checks = 0;
    int failures = 0;

    int wcnt = 0;
    int pcnt = 0;
    logic [7:0] last_wr = 8'h00;
    logic [7:0] prev_wr = 8'h00;
    int w0;
    int p0;

    usb_rx_rcu #(.MAX_BYTES(66)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .eop_detected (eop_detected),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .pid          (pid),
        .pid_valid    (pid_valid),
        .pkt_done     (pkt_done),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    // FIFO-side monitor: every pulse is one full cycle wide, so the falling
    // edge sees it exactly once.
    always @(negedge clk) begin
        if (w_enable) begin
            wcnt    = wcnt + 1;
            prev_wr = last_wr;
            last_wr = rcv_data;
        end
        if (pkt_done)
            pcnt = pcnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit();
        shift_enable = 1'b1;
        cyc();
        shift_enable = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++)
            send_bit();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rcv_data = b;
        send_bits(8);
    endtask

    task automatic pulse_d_edge();
        d_edge = 1'b1;
        cyc();
        d_edge = 1'b0;
        cyc();
    endtask

    // Two bit times of SE0 followed by one bit time of J.
    task automatic eop_seq();
        eop_detected = 1'b1;
        send_bit();
        send_bit();
        eop_detected = 1'b0;
        send_bit();
    endtask

    initial begin
        // ---------------- reset state
        cyc();
        cyc();
        check("rst_rcving", int'(rcving), 0);
        check("rst_w_enable", int'(w_enable), 0);
        check("rst_r_error", int'(r_error), 0);
        check("rst_pid", int'(pid), 0);
        check("rst_pid_valid", int'(pid_valid), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        check("rst_byte_count", int'(byte_count), 0);
        rst = 1'b0;
        cyc();
        cyc();
        check("idle_wait_rcving", int'(rcving), 0);

        // ---------------- clean packet: PID C3, data 11 22
        w0 = wcnt;
        p0 = pcnt;
        pulse_d_edge();
        check("p1_rcving", int'(rcving), 1);
        send_byte(8'h80);
        send_byte(8'hC3);
        check("p1_pid", int'(pid), 3);
        check("p1_pid_valid", int'(pid_valid), 1);
        send_byte(8'h11);
        check("p1_bc1", int'(byte_count), 1);
        pulse_d_edge();
        check("p1_d_edge_ignored", int'(byte_count), 1);
        send_byte(8'h22);
        eop_seq();
        check("p1_w_count", wcnt - w0, 2);
        check("p1_byte0", int'(prev_wr), 8'h11);
        check("p1_byte1", int'(last_wr), 8'h22);
        check("p1_byte_count", int'(byte_count), 2);
        check("p1_pkt_done", pcnt - p0, 1);
        check("p1_r_error", int'(r_error), 0);
        check("p1_rcving_idle", int'(rcving), 0);
        check("p1_pid_hold", int'(pid), 3);
        check("p1_pid_valid_hold", int'(pid_valid), 1);

        // ---------------- bad sync byte 81
        w0 = wcnt;
        p0 = pcnt;
        pulse_d_edge();
        send_byte(8'h81);
        check("p2_r_error", int'(r_error), 1);
        check("p2_rcving_err", int'(rcving), 1);
        send_byte(8'h55);
        eop_seq();
        check("p2_r_error_idle", int'(r_error), 1);
        check("p2_rcving_idle", int'(rcving), 0);
        check("p2_w_count", wcnt - w0, 0);
        check("p2_pkt_done", pcnt - p0, 0);
        pulse_d_edge();
        check("p2_r_error_clear", int'(r_error), 0);
        check("p2_pid_valid_clear", int'(pid_valid), 0);

        // ---------------- bad PID: check nibble A is not ~7 (8)
        send_byte(8'h80);
        send_byte(8'hA7);
        check("p3_r_error", int'(r_error), 1);
        check("p3_pid_valid", int'(pid_valid), 0);
        check("p3_pid_unchanged", int'(pid), 3);
        eop_seq();
        check("p3_rcving_idle", int'(rcving), 0);

        // ---------------- PID A5 (A == ~5, well formed), SE0 after 3 bits
        w0 = wcnt;
        p0 = pcnt;
        pulse_d_edge();
        send_byte(8'h80);
        send_byte(8'hA5);
        check("p4_pid", int'(pid), 5);
        check("p4_pid_valid", int'(pid_valid), 1);
        send_byte(8'h33);
        check("p4_bc1", int'(byte_count), 1);
        rcv_data = 8'h07;
        send_bits(3);
        eop_seq();
        check("p4_r_error", int'(r_error), 1);
        check("p4_byte_count", int'(byte_count), 1);
        check("p4_w_count", wcnt - w0, 1);
        check("p4_pkt_done", pcnt - p0, 0);

        // ---------------- overflow: 67 data bytes, 66 allowed
        w0 = wcnt;
        p0 = pcnt;
        pulse_d_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        for (int i = 0; i < 66; i++)
            send_byte(8'(i + 1));
        check("p5_bc66", int'(byte_count), 66);
        check("p5_no_err_yet", int'(r_error), 0);
        check("p5_last_byte", int'(last_wr), 66);
        send_byte(8'hEE);
        check("p5_r_error", int'(r_error), 1);
        check("p5_byte_count_sat", int'(byte_count), 66);
        check("p5_w_count", wcnt - w0, 66);
        eop_seq();
        check("p5_pkt_done", pcnt - p0, 0);
        check("p5_byte_count_hold", int'(byte_count), 66);

        // ---------------- reset mid-DATA, then a clean packet
        pulse_d_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h44);
        rcv_data = 8'h0F;
        send_bits(4);
        w0 = wcnt;
        p0 = pcnt;
        #2 rst = 1'b1;
        #1;
        check("p6_rst_rcving", int'(rcving), 0);
        check("p6_rst_byte_count", int'(byte_count), 0);
        check("p6_rst_pid", int'(pid), 0);
        check("p6_rst_pid_valid", int'(pid_valid), 0);
        check("p6_rst_r_error", int'(r_error), 0);
        send_bits(4);
        #3 rst = 1'b0;
        cyc();
        check("p6_rst_w_count", wcnt - w0, 0);
        check("p6_rst_pkt_done", pcnt - p0, 0);
        pulse_d_edge();
        send_byte(8'h80);
        send_byte(8'h69);
        send_byte(8'hAB);
        send_byte(8'hCD);
        eop_seq();
        check("p6_pid", int'(pid), 9);
        check("p6_pid_valid", int'(pid_valid), 1);
        check("p6_byte_count", int'(byte_count), 2);
        check("p6_w_count", wcnt - w0, 2);
        check("p6_byte0", int'(prev_wr), 8'hAB);
        check("p6_byte1", int'(last_wr), 8'hCD);
        check("p6_pkt_done", pcnt - p0, 1);
        check("p6_r_error", int'(r_error), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
